// File: rtl/uart_cmd_frame_decoder.sv
// Command frame decoder fed by the UART receiver: assembles HEADER/cmd/value/checksum
// frames, drives the video-control registers and returns an ACK/NAK byte to the transmitter.
module uart_cmd_frame_decoder #(
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 25000,
    parameter logic [7:0]  ACK_BYTE    = 8'h06,
    parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic [7:0] I_rx_data,
    input  logic       I_rx_valid,
    input  logic       I_tx_busy,
    output logic       O_tx_wreq,
    output logic [7:0] O_tx_wdata,
    output logic       O_split_full_flag,
    output logic [3:0] O_screen_switch,
    output logic       O_video_move_en,
    output logic       O_cmd_valid,
    output logic       O_frame_err,
    output logic [1:0] O_err_code
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {HUNT, CMD, VAL, CSUM} state_t;

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_to_cnt;
    logic [7:0]    r_cmd, r_val, r_reply;
    logic          r_pending;
    logic          w_good, w_bad, w_timeout, w_issue;
    logic [1:0]    w_code;
    logic [7:0]    w_sum;

    always_comb begin
        w_state_next = r_state;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        w_timeout    = 1'b0;
        w_code       = 2'd0;
        w_sum        = r_cmd + r_val;
        if (r_state != HUNT && !I_rx_valid && r_to_cnt == CW'(TIMEOUT_CYC - 1)) begin
            w_state_next = HUNT;
            w_timeout    = 1'b1;
        end else if (I_rx_valid) begin
            case (r_state)
                HUNT: if (I_rx_data == HEADER) w_state_next = CMD;
                CMD:  w_state_next = VAL;
                VAL:  w_state_next = CSUM;
                CSUM: begin
                    w_state_next = HUNT;
                    // Checksum mismatch outranks an unknown command.
                    if (I_rx_data != w_sum) begin
                        w_bad  = 1'b1;
                        w_code = 2'd1;
                    end else begin
                        case (r_cmd)
                            8'h01, 8'h03: w_good = 1'b1;
                            8'h02: begin
                                w_good = (r_val[7:4] == 4'h0);
                                w_bad  = (r_val[7:4] != 4'h0);
                                w_code = 2'd2;
                            end
                            default: begin
                                w_bad  = 1'b1;
                                w_code = 2'd2;
                            end
                        endcase
                    end
                end
                default: w_state_next = HUNT;
            endcase
        end
    end

    assign w_issue = r_pending & ~I_tx_busy;

    always_ff @(posedge I_clk) begin
        if (I_rst) r_state <= HUNT;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_to_cnt          <= '0;
            r_cmd             <= '0;
            r_val             <= '0;
            r_reply           <= '0;
            r_pending         <= 1'b0;
            O_tx_wreq         <= 1'b0;
            O_tx_wdata        <= '0;
            O_split_full_flag <= 1'b0;
            O_screen_switch   <= '0;
            O_video_move_en   <= 1'b0;
            O_cmd_valid       <= 1'b0;
            O_frame_err       <= 1'b0;
            O_err_code        <= '0;
        end else begin
            O_cmd_valid <= w_good;
            O_frame_err <= w_bad | w_timeout;

            if (r_state == HUNT || I_rx_valid) r_to_cnt <= '0;
            else                               r_to_cnt <= r_to_cnt + 1'b1;

            if (r_state == CMD && I_rx_valid) r_cmd <= I_rx_data;
            if (r_state == VAL && I_rx_valid) r_val <= I_rx_data;

            if (w_timeout)  O_err_code <= 2'd3;
            else if (w_bad) O_err_code <= w_code;

            if (w_good) begin
                case (r_cmd)
                    8'h01:   O_split_full_flag <= r_val[0];
                    8'h02:   O_screen_switch   <= r_val[3:0];
                    default: O_video_move_en   <= r_val[0];
                endcase
            end

            // Registered request: a reply pending while the transmitter is idle goes out next cycle.
            O_tx_wreq <= w_issue;
            if (w_issue) O_tx_wdata <= r_reply;

            if (w_good || w_bad || w_timeout) begin
                r_pending <= 1'b1;
                r_reply   <= w_good ? ACK_BYTE : NAK_BYTE;
            end else if (w_issue) begin
                r_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_frame_decoder.sv
// Self-checking bench for uart_cmd_frame_decoder: directed and randomized frames compared
// against a frame-level reference model.
module tb_uart_cmd_frame_decoder;

    localparam int unsigned TO  = 25000;
    localparam logic [7:0]  HDR = 8'hA5;
    localparam logic [7:0]  ACK = 8'h06;
    localparam logic [7:0]  NAK = 8'h15;

    logic       clk = 1'b0;
    logic       rst, rx_valid, tx_busy;
    logic [7:0] rx_data;
    logic       tx_wreq, split, move_en, cmd_valid, frame_err;
    logic [7:0] tx_wdata;
    logic [3:0] screen;
    logic [1:0] err_code;

    uart_cmd_frame_decoder #(.TIMEOUT_CYC(TO)) dut (
        .I_clk(clk), .I_rst(rst), .I_rx_data(rx_data), .I_rx_valid(rx_valid),
        .I_tx_busy(tx_busy), .O_tx_wreq(tx_wreq), .O_tx_wdata(tx_wdata),
        .O_split_full_flag(split), .O_screen_switch(screen), .O_video_move_en(move_en),
        .O_cmd_valid(cmd_valid), .O_frame_err(frame_err), .O_err_code(err_code)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_wr = 0, n_cv = 0, n_fe = 0, wr_cyc = 0, cv_cyc = 0, fe_cyc = 0;
    logic [7:0]  wr_data = 8'h00;
    always @(negedge clk) begin
        if (tx_wreq)   begin n_wr++; wr_data = tx_wdata; wr_cyc = cyc; end
        if (cmd_valid) begin n_cv++; cv_cyc = cyc; end
        if (frame_err) begin n_fe++; fe_cyc = cyc; end
    end

    int checks = 0, errors = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: frame-level view of the byte stream.
    logic [7:0]  q[$];
    int unsigned m_last = 0;
    logic        m_split = 0, m_move = 0;
    logic [3:0]  m_scr = 0;
    logic [1:0]  m_code = 0;
    bit          f_done, f_good;
    int unsigned f_n;

    function automatic void model_idle(input int unsigned now);
        if (q.size() > 0 && now - m_last > TO) begin
            q.delete();
            m_code = 2'd3;
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b, input int unsigned n);
        logic [7:0] sum;
        f_done = 0;
        model_idle(n);
        if (q.size() == 0) begin
            if (b == HDR) begin q.push_back(b); m_last = n; end
        end else begin
            q.push_back(b);
            m_last = n;
            if (q.size() == 4) begin
                f_done = 1; f_n = n; f_good = 0;
                sum = q[1] + q[2];
                if (q[3] != sum) m_code = 2'd1;
                else if (q[1] == 8'h01) begin f_good = 1; m_split = q[2][0]; end
                else if (q[1] == 8'h02 && q[2] < 8'h10) begin f_good = 1; m_scr = q[2][3:0]; end
                else if (q[1] == 8'h03) begin f_good = 1; m_move = q[2][0]; end
                else m_code = 2'd2;
                q.delete();
            end
        end
    endfunction

    task automatic put(input logic [7:0] b, output int unsigned n);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = b; n = cyc;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_data = 8'($urandom);
    endtask

    task automatic send(input logic [7:0] b, output int unsigned n);
        put(b, n);
        model_byte(b, n);
    endtask

    task automatic idle_until(input int unsigned t);
        while (cyc + 1 < t) begin @(posedge clk); #1; end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_split"}, split, m_split);
        chk({tag, "_screen"}, screen, m_scr);
        chk({tag, "_move"}, move_en, m_move);
        chk({tag, "_errcode"}, err_code, m_code);
    endtask

    int unsigned b_cv, b_fe, b_wr;
    task automatic snap();
        b_cv = n_cv; b_fe = n_fe; b_wr = n_wr;
    endtask

    // Checks the frame completed by the most recent send, then its reply.
    task automatic expect_frame(input string tag, input bit exp_tx);
        repeat (3) begin @(posedge clk); #1; end
        chk({tag, "_done"}, f_done, 1);
        chk({tag, "_cv_cnt"}, n_cv - b_cv, f_good ? 1 : 0);
        chk({tag, "_fe_cnt"}, n_fe - b_fe, f_good ? 0 : 1);
        if (f_good) chk({tag, "_cv_cyc"}, cv_cyc, f_n + 1);
        else        chk({tag, "_fe_cyc"}, fe_cyc, f_n + 1);
        chk({tag, "_wr_cnt"}, n_wr - b_wr, exp_tx ? 1 : 0);
        if (exp_tx) begin
            chk({tag, "_wr_cyc"}, wr_cyc, f_n + 2);
            chk({tag, "_wr_data"}, wr_data, f_good ? ACK : NAK);
        end
        chk_outputs(tag);
    endtask

    task automatic frame(input string tag, input logic [7:0] c, input logic [7:0] v,
                         input logic [7:0] s, input bit exp_tx);
        int unsigned n;
        snap();
        send(HDR, n); send(c, n); send(v, n); send(s, n);
        expect_frame(tag, exp_tx);
    endtask

    initial begin
        int unsigned n, t, r, b2_wr;
        logic [7:0] c, v, s, j;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_wreq", tx_wreq, 0);
        chk("rst_wdata", tx_wdata, 0);
        chk("rst_cv", cmd_valid, 0);
        chk("rst_fe", frame_err, 0);
        chk_outputs("rst");
        rst = 1'b0;

        frame("split1", 8'h01, 8'h01, 8'h02, 1);
        frame("scr3", 8'h02, 8'h03, 8'h05, 1);
        frame("badsum", 8'h02, 8'h03, 8'h06, 1);

        snap();
        send(8'h12, n); send(8'h34, n);
        repeat (4) begin @(posedge clk); #1; end
        chk("junk_wr", n_wr - b_wr, 0);
        chk("junk_fe", n_fe - b_fe, 0);
        frame("move1", 8'h03, 8'h01, 8'h04, 1);
        frame("unk07", 8'h07, 8'h00, 8'h07, 1);
        frame("scr_hi", 8'h02, 8'h13, 8'h15, 1);
        frame("wrapsum", 8'h03, 8'hFF, 8'h02, 1);

        // Inter-byte timeout mid-frame.
        snap();
        send(HDR, n); send(8'h01, n);
        idle_until(n + TO + 6);
        chk("to_fe_cnt", n_fe - b_fe, 1);
        chk("to_fe_cyc", fe_cyc, n + TO + 1);
        chk("to_cv_cnt", n_cv - b_cv, 0);
        chk("to_wr_cnt", n_wr - b_wr, 1);
        chk("to_wr_cyc", wr_cyc, n + TO + 2);
        chk("to_wr_data", wr_data, NAK);
        model_idle(cyc);
        chk_outputs("to");
        frame("after_to", 8'h01, 8'h00, 8'h01, 1);

        // A byte landing on the last allowed cycle is still frame data.
        snap();
        send(HDR, n); send(8'h01, n);
        idle_until(n + TO);
        send(8'h01, t);
        chk("edge_cyc", t, n + TO);
        send(8'h02, t);
        expect_frame("edge", 1);

        // Busy held across one frame.
        tx_busy = 1'b1;
        t = cyc;
        frame("busyA", 8'h03, 8'h00, 8'h03, 0);
        b2_wr = n_wr;
        idle_until(t + 500);
        @(posedge clk); #1;
        tx_busy = 1'b0; r = cyc;
        repeat (5) begin @(posedge clk); #1; end
        chk("busyA_wr_cnt", n_wr - b2_wr, 1);
        chk("busyA_wr_cyc", wr_cyc, r + 1);
        chk("busyA_wr_data", wr_data, ACK);

        // Two replies queued under busy: only the latest is sent.
        tx_busy = 1'b1;
        t = cyc;
        b2_wr = n_wr;
        frame("busyB1", 8'h01, 8'h01, 8'h02, 0);
        frame("busyB2", 8'h03, 8'h00, 8'h04, 0);
        idle_until(t + 500);
        @(posedge clk); #1;
        tx_busy = 1'b0; r = cyc;
        repeat (20) begin @(posedge clk); #1; end
        chk("busyB_wr_cnt", n_wr - b2_wr, 1);
        chk("busyB_wr_cyc", wr_cyc, r + 1);
        chk("busyB_wr_data", wr_data, NAK);

        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                do j = 8'($urandom); while (j == HDR);
                send(j, n);
            end
            c = 8'($urandom_range(0, 4));
            v = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            s = c + v;
            if ($urandom_range(0, 3) == 0) s = s ^ 8'(1 << $urandom_range(0, 7));
            frame("rand", c, v, s, 1);
            repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
        end

        // Reset mid-frame, then stray bytes are discarded.
        send(HDR, n); send(8'h02, n);
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        q.delete(); m_split = 0; m_scr = 0; m_move = 0; m_code = 0;
        chk("mrst_wdata", tx_wdata, 0);
        chk("mrst_wreq", tx_wreq, 0);
        chk_outputs("mrst");
        snap();
        send(8'h03, n); send(8'h04, n);
        repeat (6) begin @(posedge clk); #1; end
        chk("mrst_wr_cnt", n_wr - b_wr, 0);
        chk("mrst_fe_cnt", n_fe - b_fe, 0);
        chk("mrst_cv_cnt", n_cv - b_cv, 0);
        chk_outputs("mrst_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
